// File: rtl/mem_master_if.sv
// Command/response and memory-side signal bundle for mem_master.
// The master modport is the mem_master's own view; slave is the environment's view.
interface mem_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_wr;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  wr;
  logic                  rd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  response;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rdata, response,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, wr, rd, addr, wdata
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rdata, response,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, wr, rd, addr, wdata
  );
endinterface

// File: rtl/mem_master.sv
// Single-outstanding memory master: turns a command handshake into a held wr/rd
// strobe, waits for the memory response or a timeout, and reports a one-cycle completion.
module mem_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_SIZE   = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                clk,
  input  logic                reset,
  mem_master_if.master        bus,
  output logic [7:0]          err_count
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state, state_next;
  logic [CW-1:0]         timer, timer_next;
  logic                  wr_next, rd_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic                  rsp_valid_next, rsp_err_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_next;
  logic                  in_range;

  assign bus.cmd_ready = (state == IDLE);
  assign in_range      = (32'(bus.cmd_addr) < MEM_SIZE);

  always_comb begin
    state_next     = state;
    timer_next     = timer;
    wr_next        = bus.wr;
    rd_next        = bus.rd;
    addr_next      = bus.addr;
    wdata_next     = bus.wdata;
    rsp_err_next   = bus.rsp_err;
    rsp_rdata_next = bus.rsp_rdata;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (in_range) begin
            state_next = ACCESS;
            addr_next  = bus.cmd_addr;
            wdata_next = bus.cmd_wdata;
            wr_next    = bus.cmd_wr;
            rd_next    = ~bus.cmd_wr;
            timer_next = '0;
          end else begin
            state_next     = RESP;
            rsp_err_next   = 1'b1;
            rsp_rdata_next = '0;
          end
        end
      end
      ACCESS: begin
        // A response arriving on the final allowed cycle still counts as success.
        if (bus.response) begin
          state_next     = RESP;
          wr_next        = 1'b0;
          rd_next        = 1'b0;
          rsp_err_next   = 1'b0;
          rsp_rdata_next = bus.rd ? bus.rdata : '0;
        end else if (timer == CW'(TIMEOUT - 1)) begin
          state_next     = RESP;
          wr_next        = 1'b0;
          rd_next        = 1'b0;
          rsp_err_next   = 1'b1;
          rsp_rdata_next = '0;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    rsp_valid_next = (state_next == RESP);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      timer         <= '0;
      bus.wr        <= 1'b0;
      bus.rd        <= 1'b0;
      bus.addr      <= '0;
      bus.wdata     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
      err_count     <= '0;
    end else begin
      state         <= state_next;
      timer         <= timer_next;
      bus.wr        <= wr_next;
      bus.rd        <= rd_next;
      bus.addr      <= addr_next;
      bus.wdata     <= wdata_next;
      bus.rsp_valid <= rsp_valid_next;
      bus.rsp_err   <= rsp_err_next;
      bus.rsp_rdata <= rsp_rdata_next;
      if (state == RESP && bus.rsp_err && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Directed self-checking bench for mem_master: transfers, out-of-range, timeout,
// timeout boundary, mid-access reset, back-to-back error saturation and stray responses.
module tb_mem_master;

  logic       clk;
  logic       reset;
  logic [7:0] err_count;
  int         check_count = 0;
  int         pass_count  = 0;

  mem_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

  mem_master #(
    .ADDR_WIDTH(8), .DATA_WIDTH(16), .MEM_SIZE(16), .TIMEOUT(15)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Issue one command, play the memory side, and check the completion it produces.
  task automatic applyStimulus(input string tag, input logic is_wr, input logic [7:0] a,
                               input logic [15:0] d, input int resp_delay,
                               input logic [15:0] mem_rdata, input logic exp_err,
                               input logic [15:0] exp_rdata, input int exp_strobes,
                               input int exp_latency);
    int n, strobes, bad;
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = is_wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    checkOutput({tag, "_ready"}, bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    n = 0; strobes = 0; bad = 0;
    while (!bus.rsp_valid && n < 100) begin
      if (bus.wr || bus.rd) begin
        strobes++;
        if (bus.wr !== is_wr || bus.rd !== !is_wr || bus.addr !== a || bus.wdata !== d)
          bad++;
      end
      bus.response = (resp_delay != 0 && n + 1 == resp_delay);
      bus.rdata    = mem_rdata;
      tick();
      n++;
    end
    bus.response = 1'b0;
    checkOutput({tag, "_rsp_valid"}, bus.rsp_valid, 1);
    checkOutput({tag, "_rsp_err"},   bus.rsp_err, exp_err);
    checkOutput({tag, "_rsp_rdata"}, bus.rsp_rdata, exp_rdata);
    checkOutput({tag, "_strobes"},   strobes, exp_strobes);
    checkOutput({tag, "_stable"},    bad, 0);
    checkOutput({tag, "_latency"},   n + 1, exp_latency);
    tick();
    checkOutput({tag, "_rsp_one_cycle"}, bus.rsp_valid, 0);
    checkOutput({tag, "_back_idle"},     bus.cmd_ready, 1);
  endtask

  initial begin
    int pulses;
    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rdata     = '0;
    bus.response  = 1'b0;
    reset         = 1'b0;
    tick();
    tick();
    checkOutput("rst_cmd_ready", bus.cmd_ready, 1);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst_wr",        bus.wr, 0);
    checkOutput("rst_rd",        bus.rd, 0);
    checkOutput("rst_addr",      bus.addr, 0);
    checkOutput("rst_wdata",     bus.wdata, 0);
    checkOutput("rst_rsp_err",   bus.rsp_err, 0);
    checkOutput("rst_rsp_rdata", bus.rsp_rdata, 0);
    checkOutput("rst_err_count", err_count, 0);
    reset = 1'b1;
    tick();

    applyStimulus("write3",   1'b1, 8'd3,  16'hA5A5, 2,  16'h1234, 1'b0, 16'h0000, 2,  3);
    applyStimulus("read3",    1'b0, 8'd3,  16'h0000, 1,  16'hA5A5, 1'b0, 16'hA5A5, 1,  2);
    checkOutput("errcnt_after_ok", err_count, 0);
    applyStimulus("oor16",    1'b0, 8'd16, 16'h0000, 1,  16'h7777, 1'b1, 16'h0000, 0,  1);
    checkOutput("errcnt_after_oor", err_count, 1);
    applyStimulus("read15",   1'b0, 8'd15, 16'h0000, 3,  16'h5A5A, 1'b0, 16'h5A5A, 3,  4);
    applyStimulus("timeout5", 1'b0, 8'd5,  16'h0000, 0,  16'hFFFF, 1'b1, 16'h0000, 15, 16);
    checkOutput("errcnt_after_to", err_count, 2);
    applyStimulus("edge7",    1'b0, 8'd7,  16'h0000, 15, 16'h0BEE, 1'b0, 16'h0BEE, 15, 16);
    applyStimulus("wr_oor",   1'b1, 8'd200, 16'h1111, 1, 16'h0000, 1'b1, 16'h0000, 0,  1);
    checkOutput("errcnt_after_wroor", err_count, 3);

    // Reset lands while a read is waiting on memory.
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = 8'd5;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    checkOutput("midrst_rd_before", bus.rd, 1);
    reset = 1'b0;
    tick();
    checkOutput("midrst_rd",        bus.rd, 0);
    checkOutput("midrst_wr",        bus.wr, 0);
    checkOutput("midrst_cmd_ready", bus.cmd_ready, 1);
    checkOutput("midrst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("midrst_err_count", err_count, 0);
    reset  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.rsp_valid) pulses++;
    end
    checkOutput("midrst_no_rsp", pulses, 0);

    // Held cmd_valid with an out-of-range address: one completion every two cycles.
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = 8'd16;
    pulses        = 0;
    for (int i = 0; i < 520; i++) begin
      tick();
      if (bus.rsp_valid) pulses++;
      if (bus.rd || bus.wr) pulses += 1000;
    end
    bus.cmd_valid = 1'b0;
    checkOutput("sat_pulses",    pulses, 260);
    checkOutput("sat_err_count", err_count, 255);

    bus.response = 1'b1;
    pulses       = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.rsp_valid || bus.rd || bus.wr) pulses++;
    end
    bus.response = 1'b0;
    checkOutput("stray_resp_ignored", pulses, 0);
    checkOutput("stray_err_count",    err_count, 255);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, the address bus width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, the data bus width.
REQ-003 The block SHALL have parameter MEM_SIZE, default 16, the number of valid memory words (addresses 0..MEM_SIZE-1).
REQ-004 The block SHALL have parameter TIMEOUT, default 15, the maximum number of ACCESS cycles to wait for response.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-008 The block SHALL have port cmd_ready, output, 1 bit: a command can be accepted.
REQ-009 The block SHALL have port cmd_wr, input, 1 bit: 1 = write, 0 = read.
REQ-010 The block SHALL have port cmd_addr, input, ADDR_WIDTH bits: command address.
REQ-011 The block SHALL have port cmd_wdata, input, DATA_WIDTH bits: write data.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: a one-cycle completion pulse.
REQ-013 The block SHALL have port rsp_rdata, output, DATA_WIDTH bits: read data, valid with rsp_valid.
REQ-014 The block SHALL have port rsp_err, output, 1 bit: the command failed (address out of range or timeout), valid with rsp_valid.
REQ-015 The block SHALL have port wr, output, 1 bit: memory write strobe.
REQ-016 The block SHALL have port rd, output, 1 bit: memory read strobe.
REQ-017 The block SHALL have port addr, output, ADDR_WIDTH bits: memory address.
REQ-018 The block SHALL have port wdata, output, DATA_WIDTH bits: memory write data.
REQ-019 The block SHALL have port rdata, input, DATA_WIDTH bits: memory read data, sampled when response=1.
REQ-020 The block SHALL have port response, input, 1 bit: the memory completion indication.
REQ-021 The block SHALL have port err_count, output, 8 bits: a saturating count of error completions.

Function
REQ-022 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP, with all outputs registered except cmd_ready.
REQ-023 cmd_ready SHALL equal (state==IDLE); a command is accepted on a cycle with cmd_valid=1 and cmd_ready=1.
REQ-024 On acceptance with cmd_addr<MEM_SIZE, the FSM SHALL go to ACCESS next cycle, with addr/wdata loaded, wr=cmd_wr and rd=~cmd_wr; the timeout counter SHALL clear to 0.
REQ-025 On acceptance with cmd_addr>=MEM_SIZE, the FSM SHALL go directly to RESP with rsp_err=1 and rsp_rdata=0; wr and rd SHALL never assert.
REQ-026 In ACCESS, addr, wdata, wr and rd SHALL be held stable, and exactly one of wr/rd SHALL be 1.
REQ-027 In ACCESS with response=1, the FSM SHALL go to RESP next cycle with wr=rd=0, rsp_err=0, and rsp_rdata=rdata for a read or 0 for a write.
REQ-028 In ACCESS with response=0, the counter SHALL increment; when the counter equals TIMEOUT-1 and response=0, the FSM SHALL go to RESP with wr=rd=0, rsp_err=1 and rsp_rdata=0.
REQ-029 A response on the same cycle as the timeout condition SHALL win, and the completion SHALL be successful.
REQ-030 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; rsp_valid SHALL be 0 in every other state.
REQ-031 Minimum latency from acceptance to rsp_valid SHALL be 2 cycles when response=1 on the first ACCESS cycle, and 1 cycle for an out-of-range address.
REQ-032 response while in IDLE or RESP SHALL be ignored.
REQ-033 err_count SHALL increment by 1 on each RESP cycle with rsp_err=1 and SHALL saturate at 255.
REQ-034 Back-to-back commands SHALL be allowed: with cmd_valid held, a new command is accepted on the IDLE cycle following RESP.

Reset
REQ-035 When reset=0 at a clock edge, the block SHALL set state=IDLE, wr=rd=0, addr=0, wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, err_count=0 and the counter to 0.
REQ-036 Reset asserted mid-ACCESS SHALL abort the transaction with no rsp_valid, and wr/rd SHALL be 0 from the next cycle.
REQ-037 Reset SHALL take priority over all other inputs.

Verification
REQ-038 Write then read: write addr 3, data 16'hA5A5, with response after 2 cycles -> wr=1 held for 2 cycles, then rsp_valid with rsp_err=0; read addr 3 with memory returning 16'hA5A5 -> rsp_rdata=16'hA5A5.
REQ-039 Out of range: read addr 16 -> no rd pulse; rsp_valid one cycle after acceptance with rsp_err=1; err_count=1.
REQ-040 Timeout: read addr 5 with response tied to 0 -> rd high for exactly 15 cycles, then rsp_err=1 and rsp_rdata=0.
REQ-041 Boundary: response arrives on the 15th ACCESS cycle -> success with rsp_err=0.
REQ-042 Reset mid-operation: reset=0 during ACCESS -> next cycle rd=wr=0, cmd_ready=1, and no rsp_valid.
REQ-043 Saturation: 260 out-of-range commands -> err_count=255; stray response pulses in IDLE -> no rsp_valid.
